traffic_lights_cmd_gen: RTL

Command transmitter for the traffic_lights command interface (cmd_type/cmd_valid/cmd_data).
- Accepts one high-level request per valid/ready handshake: load phase times, switch on, or switch off.
- Serialises each request into the exact command sequence traffic_lights expects.
- Sits between a host/register block and traffic_lights, replacing hand-driven command sequences.

---
 rtl/traffic_lights_pkg.sv | 69 ++++++
 rtl/traffic_lights_cmd_gen.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/traffic_lights_pkg.sv
// Shared types for traffic_lights and its command generator.
// Holds command codes, request ops and generator FSM states plus sequencing helpers.
package traffic_lights_pkg;

  localparam int unsigned CMD_W  = 3;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned TIME_W = 16;

  typedef enum logic [CMD_W-1:0] {
    CMD_ON           = 3'd0,
    CMD_OFF          = 3'd1,
    CMD_NOTRANSITION = 3'd2,
    CMD_SET_GREEN    = 3'd3,
    CMD_SET_RED      = 3'd4,
    CMD_SET_YELLOW   = 3'd5
  } cmd_code_e;

  typedef enum logic [OP_W-1:0] {
    OP_LOAD_TIMES = 2'd0,
    OP_TURN_ON    = 2'd1,
    OP_TURN_OFF   = 2'd2,
    OP_RESERVED   = 2'd3
  } req_op_e;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_NOTRANS = 4'd1,
    ST_SET_G   = 4'd2,
    ST_SET_R   = 4'd3,
    ST_SET_Y   = 4'd4,
    ST_ON      = 4'd5,
    ST_OFF     = 4'd6,
    ST_GAP     = 4'd7,
    ST_DONE    = 4'd8
  } gen_state_e;

  // First command state of a request; ST_DONE means nothing is issued.
  function automatic gen_state_e first_state(input req_op_e op);
    case (op)
      OP_LOAD_TIMES: return ST_NOTRANS;
      OP_TURN_ON:    return ST_ON;
      OP_TURN_OFF:   return ST_OFF;
      default:       return ST_DONE;
    endcase
  endfunction

  // Command that follows the given one; ST_DONE marks the end of a sequence.
  function automatic gen_state_e next_state(input gen_state_e st);
    case (st)
      ST_NOTRANS: return ST_SET_G;
      ST_SET_G:   return ST_SET_R;
      ST_SET_R:   return ST_SET_Y;
      ST_SET_Y:   return ST_ON;
      default:    return ST_DONE;
    endcase
  endfunction

  function automatic cmd_code_e state_cmd(input gen_state_e st);
    case (st)
      ST_NOTRANS: return CMD_NOTRANSITION;
      ST_SET_G:   return CMD_SET_GREEN;
      ST_SET_R:   return CMD_SET_RED;
      ST_SET_Y:   return CMD_SET_YELLOW;
      ST_OFF:     return CMD_OFF;
      default:    return CMD_ON;
    endcase
  endfunction

endpackage

// File: rtl/traffic_lights_cmd_gen.sv
// Serialises LOAD_TIMES / TURN_ON / TURN_OFF requests into traffic_lights commands.
// Optional time-field clamping is compiled in with TRAFFIC_LIGHTS_CMD_GEN_CLAMP_EN.
module traffic_lights_cmd_gen
  import traffic_lights_pkg::*;
#(
  parameter int unsigned CMD_GAP     = 0,
  parameter int unsigned MIN_TIME_MS = 1
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [OP_W-1:0]   req_op_i,
  input  logic [TIME_W-1:0] req_red_ms_i,
  input  logic [TIME_W-1:0] req_yellow_ms_i,
  input  logic [TIME_W-1:0] req_green_ms_i,
  output logic [CMD_W-1:0]  cmd_type_o,
  output logic              cmd_valid_o,
  output logic [TIME_W-1:0] cmd_data_o,
  output logic              busy_o,
  output logic              done_o
`ifdef TRAFFIC_LIGHTS_CMD_GEN_CLAMP_EN
  ,
  output logic              clamp_o
`endif
);

  localparam int unsigned GAP_W = (CMD_GAP > 0) ? $clog2(CMD_GAP + 1) : 1;
  localparam logic [TIME_W-1:0] MIN_T = TIME_W'(MIN_TIME_MS);
`ifdef TRAFFIC_LIGHTS_CMD_GEN_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  gen_state_e        state;
  gen_state_e        pend_st;
  logic [GAP_W-1:0]  gap_cnt;
  logic [TIME_W-1:0] red_q;
  logic [TIME_W-1:0] yel_q;
  logic [TIME_W-1:0] grn_q;

  gen_state_e        first_c;
  gen_state_e        nxt_c;
  logic [TIME_W-1:0] nxt_data_c;
  logic [TIME_W-1:0] pend_data_c;

  function automatic logic [TIME_W-1:0] fix_time(input logic [TIME_W-1:0] t);
    return (CLAMP_EN && (t < MIN_T)) ? MIN_T : t;
  endfunction

  function automatic logic [TIME_W-1:0] payload(input gen_state_e st,
                                                input logic [TIME_W-1:0] r,
                                                input logic [TIME_W-1:0] y,
                                                input logic [TIME_W-1:0] g);
    case (st)
      ST_SET_G: return g;
      ST_SET_R: return r;
      ST_SET_Y: return y;
      default:  return '0;
    endcase
  endfunction

  assign req_ready_o = (state == ST_IDLE) && !srst_i;
  assign first_c     = first_state(req_op_e'(req_op_i));
  assign nxt_c       = next_state(state);
  assign nxt_data_c  = payload(nxt_c, red_q, yel_q, grn_q);
  assign pend_data_c = payload(pend_st, red_q, yel_q, grn_q);

`ifdef TRAFFIC_LIGHTS_CMD_GEN_CLAMP_EN
  logic needs_clamp_c;
  assign needs_clamp_c = (req_red_ms_i < MIN_T) || (req_yellow_ms_i < MIN_T) ||
                         (req_green_ms_i < MIN_T);
`endif

  // Sequencer: state register and registered command outputs.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state       <= ST_IDLE;
      pend_st     <= ST_IDLE;
      gap_cnt     <= '0;
      red_q       <= '0;
      yel_q       <= '0;
      grn_q       <= '0;
      cmd_valid_o <= 1'b0;
      cmd_type_o  <= '0;
      cmd_data_o  <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
`ifdef TRAFFIC_LIGHTS_CMD_GEN_CLAMP_EN
      clamp_o     <= 1'b0;
`endif
    end else begin
      cmd_valid_o <= 1'b0;
      cmd_type_o  <= '0;
      cmd_data_o  <= '0;
      done_o      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid_i) begin
            red_q <= fix_time(req_red_ms_i);
            yel_q <= fix_time(req_yellow_ms_i);
            grn_q <= fix_time(req_green_ms_i);
`ifdef TRAFFIC_LIGHTS_CMD_GEN_CLAMP_EN
            clamp_o <= needs_clamp_c;
`endif
            if (first_c == ST_DONE) begin
              done_o <= 1'b1;
            end else begin
              // Opening commands (NOTRANSITION, ON, OFF) never carry a payload.
              state       <= first_c;
              busy_o      <= 1'b1;
              cmd_valid_o <= 1'b1;
              cmd_type_o  <= state_cmd(first_c);
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            state       <= pend_st;
            cmd_valid_o <= 1'b1;
            cmd_type_o  <= state_cmd(pend_st);
            cmd_data_o  <= pend_data_c;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          if (nxt_c == ST_DONE) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else if (CMD_GAP == 0) begin
            state       <= nxt_c;
            cmd_valid_o <= 1'b1;
            cmd_type_o  <= state_cmd(nxt_c);
            cmd_data_o  <= nxt_data_c;
          end else begin
            state   <= ST_GAP;
            pend_st <= nxt_c;
            gap_cnt <= GAP_W'(CMD_GAP - 1);
          end
        end
      endcase
    end
  end

endmodule
